// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb
//   Merges pipeline writeback (p0), post-increment update (p1) and a buffered
//   asynchronous write source onto the two regfile write ports. Asynchronous
//   writes wait in a small FIFO and drain into idle port slots. A stall is
//   requested when the FIFO starves, and a pending-write lookup lets decode
//   interlock on queued destinations.
// Ports:
//   clk, rst_n, clk_en                      clock, async active-low reset, cycle enable
//   p0_*/p1_*                               pipeline write sources (always accepted)
//   a_valid/a_ready, a_addr/a_data/a_no_alias  asynchronous write request handshake
//   wen0/waddr0/wdata0/write0_no_alias      regfile write port 0
//   wen1/waddr1/wdata1/write1_no_alias      regfile write port 1
//   chk_addr0/1 -> chk_hit0/1               queued-destination lookup
//   pipe_stall_req                          registered request to free port 1
//   q_count                                 FIFO occupancy
module regfile_wr_arb #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         p0_valid,
  input  logic [4:0]                   p0_addr,
  input  logic [31:0]                  p0_data,
  input  logic                         p0_no_alias,
  input  logic                         p1_valid,
  input  logic [4:0]                   p1_addr,
  input  logic [31:0]                  p1_data,
  input  logic                         p1_no_alias,
  input  logic                         a_valid,
  input  logic [4:0]                   a_addr,
  input  logic [31:0]                  a_data,
  input  logic                         a_no_alias,
  output logic                         a_ready,
  output logic                         wen0,
  output logic [4:0]                   waddr0,
  output logic [31:0]                  wdata0,
  output logic                         write0_no_alias,
  output logic                         wen1,
  output logic [4:0]                   waddr1,
  output logic [31:0]                  wdata1,
  output logic                         write1_no_alias,
  input  logic [4:0]                   chk_addr0,
  input  logic [4:0]                   chk_addr1,
  output logic                         chk_hit0,
  output logic                         chk_hit1,
  output logic                         pipe_stall_req,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        no_alias;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [WW-1:0] wait_cnt;

  entry_t        head;
  logic          p0_eff;
  logic          p1_eff;
  logic          q_nempty;
  logic          conflict;
  logic          drain0;
  logic          drain1;
  logic          deq;
  logic          enq;
  logic          wr_en;
  logic [WW-1:0] wait_nxt;
  logic          stall_nxt;
  logic [PW-1:0] off;

  assign a_ready = (q_count != CW'(DEPTH));
  assign wr_en   = clk_en && rst_n;

  // Source qualification, head drain selection and enqueue decision
  always_comb begin
    p1_eff   = p1_valid && (p1_addr != 5'd0);
    p0_eff   = p0_valid && (p0_addr != 5'd0) && !(p1_eff && (p0_addr == p1_addr));
    head     = mem[rd_ptr];
    q_nempty = (q_count != '0);
    // The queued head is older than same-cycle pipeline writes, so it is dropped on a match
    conflict = q_nempty && ((p0_eff && (head.addr == p0_addr)) ||
                            (p1_eff && (head.addr == p1_addr)));
    drain0   = q_nempty && !conflict && !p0_eff;
    drain1   = q_nempty && !conflict && p0_eff && !p1_eff;
    deq      = clk_en && (conflict || drain0 || drain1);
    enq      = clk_en && a_valid && a_ready && (a_addr != 5'd0);
  end

  // Write port muxing
  always_comb begin
    wen0            = wr_en && (p0_eff || drain0);
    waddr0          = drain0 ? head.addr     : p0_addr;
    wdata0          = drain0 ? head.data     : p0_data;
    write0_no_alias = drain0 ? head.no_alias : p0_no_alias;
    wen1            = wr_en && (p1_eff || drain1);
    waddr1          = drain1 ? head.addr     : p1_addr;
    wdata1          = drain1 ? head.data     : p1_data;
    write1_no_alias = drain1 ? head.no_alias : p1_no_alias;
  end

  // Pending lookup over the occupied window [rd_ptr, rd_ptr + q_count)
  always_comb begin
    chk_hit0 = 1'b0;
    chk_hit1 = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (CW'(off) < q_count) begin
        if ((chk_addr0 != 5'd0) && (mem[i].addr == chk_addr0)) chk_hit0 = 1'b1;
        if ((chk_addr1 != 5'd0) && (mem[i].addr == chk_addr1)) chk_hit1 = 1'b1;
      end
    end
  end

  // Starvation counter and stall request
  always_comb begin
    wait_nxt = wait_cnt;
    if (deq || !q_nempty) begin
      wait_nxt = '0;
    end else if (wait_cnt != WW'(MAX_WAIT)) begin
      wait_nxt = wait_cnt + WW'(1);
    end
    stall_nxt = deq ? 1'b0 : (pipe_stall_req || (wait_nxt == WW'(MAX_WAIT)));
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      q_count        <= '0;
      wait_cnt       <= '0;
      pipe_stall_req <= 1'b0;
    end else if (clk_en) begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      q_count        <= q_count + CW'(enq) - CW'(deq);
      wait_cnt       <= wait_nxt;
      pipe_stall_req <= stall_nxt;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= entry_t'{addr: a_addr, data: a_data, no_alias: a_no_alias};
  end

endmodule
